instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the control unit. It owns the 64-bit program counter and requests 32-bit instruction words from instruction memory over a req/ack handshake. It holds each fetched word in an instruction register that the control unit decodes. The control unit's advance strobe and PC-select field choose the next PC: sequential, PC-relative branch, or register target. This stalls fetch for multi-cycle instructions until the control unit retires them.

## Interface

- RESET_PC, 64'h0, PC value loaded on reset; must be word-aligned.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  64  fetch address; equals pc.
- imem_ack  in  1  memory returns imem_data valid this cycle; ignored when imem_req=0.
- imem_data  in  32  instruction word.
- advance  in  1  control unit retires the current instruction; next PC is taken this edge.
- pc_sel  in  2  next-PC source: 00 pc+4, 01 pc+(branch_offset<<2), 10 reg_target, 11 pc+4.
- branch_offset  in  64  sign-extended word offset (the control unit's constant output).
- reg_target  in  64  byte address for register-indirect branch.
- instruction  out  32  instruction register, feeds the control unit.
- instr_valid  out  1  instruction register holds a fetched, unretired word.
- pc  out  64  address of the word in instruction.
- pc_plus4  out  64  pc+4, link value for BL.
- fetch_fault  out  1  sticky misaligned-target flag.

## Operation

- States: FETCH, HOLD, FAULT.
- **FETCH**
  - imem_req=1.
  - On an edge with imem_ack=1: instruction<=imem_data and the state moves to HOLD.
  - Otherwise the block stays in FETCH.
  - advance is ignored in FETCH.
- **HOLD**
  - imem_req=0 and instr_valid=1.
  - instruction and pc are stable while advance=0. This is how multi-cycle instructions stall fetch.
  - On an edge with advance=1: pc<=next_pc, and the state goes to FETCH if next_pc[1:0]==0, otherwise to FAULT.
- **FAULT**
  - imem_req=0, instr_valid=0, fetch_fault=1.
  - The PC still loads the offending next_pc, so the faulting address is visible on pc.
  - Only reset leaves FAULT.
- **next_pc**
  - Computed combinationally from the current pc, pc_sel, branch_offset and reg_target.
  - All adds are 64-bit modulo 2^64 and wrap silently: pc=64'hFFFF_FFFF_FFFF_FFFC with pc_sel=00 gives 0.
  - branch_offset<<2 discards its top two bits before the add. A negative offset therefore yields a backward branch.
  - With pc_sel=01 or 00 the target is always aligned, so only pc_sel=10 can fault.
- pc_plus4 = pc+4 at all times, also wrapping.
- instr_valid=1 iff the state is HOLD.
- imem_addr=pc at all times.
- **Reset** (asynchronous, any state, including mid-handshake)
  - pc=RESET_PC, state=FETCH, instruction=32'h0, instr_valid=0, fetch_fault=0.
  - A concurrent imem_ack is discarded.
  - imem_req is 1 immediately after reset deasserts.

## Timing

- imem_req, imem_addr and instr_valid are decoded from registered state and pc, with no combinational path from inputs.
- Fetch latency: the ack edge puts the word on instruction and raises instr_valid in the following cycle. With memory that acks in the same cycle as the request, one instruction retires every 2 cycles: FETCH, HOLD, FETCH, and so on.
- Memory wait states extend FETCH by one cycle per cycle that imem_ack stays low. imem_addr stays constant throughout.
- The advance edge updates pc and clears instr_valid. The new request is issued in the next cycle.
- The control unit samples instruction/pc only while instr_valid=1. Values outside HOLD are unspecified except after reset.

## Test plan

- **Reset:** assert reset mid-FETCH with imem_ack=1 and RESET_PC=64'h100.
  - After release: pc=64'h100, imem_req=1, instr_valid=0, instruction=0.
- **Sequential fetch:** same-cycle-ack memory returning words 0xA0000000+addr, with advance pulsed each HOLD and pc_sel=00.
  - pc steps 0x100, 0x104, 0x108.
  - instr_valid toggles 0/1 every cycle.
  - instruction matches each address.
- **Wait states and stall:**
  - Hold imem_ack low for 3 cycles: imem_addr stays constant and instr_valid=0.
  - Then hold advance low for 4 HOLD cycles: instruction and pc remain unchanged.
- **Branches:**
  - From pc=0x200, pc_sel=01 with branch_offset=-2 → pc=0x1F8.
  - pc_sel=01 with offset 5 → pc=0x214.
  - pc_sel=10 with reg_target=0x4000 → pc=0x4000.
  - For each, pc_plus4 reads the new pc+4 in the following HOLD.
- **Wrap:** pc=64'hFFFF_FFFF_FFFF_FFFC with pc_sel=00 → pc=0 and the fetch proceeds normally.
- **Fault:** pc_sel=10 with reg_target=0x4002 → fetch_fault=1, pc=0x4002, imem_req=0.
  - The block stays in FAULT under any advance/ack until reset clears fetch_fault.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: program counter, imem handshake, instruction register
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        advance,
  input  logic [1:0]  pc_sel,
  input  logic [63:0] branch_offset,
  input  logic [63:0] reg_target,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] next_pc;
  logic [63:0] pc_d;
  logic [31:0] instruction_d;

  assign pc_plus4  = pc + 64'd4;
  assign imem_addr = pc;

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      2'b01:   next_pc = pc + {branch_offset[61:0], 2'b00};
      2'b10:   next_pc = reg_target;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instruction <= 32'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_d;
      instruction <= instruction_d;
    end
  end

  // Outputs decode only the registered state, so no input reaches them combinationally.
  always_comb begin
    state_next    = state;
    pc_d          = pc;
    instruction_d = instruction;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;
    fetch_fault   = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instruction_d = imem_data;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (advance) begin
          pc_d       = next_pc;
          state_next = (next_pc[1:0] == 2'b00) ? FETCH : FAULT;
        end
      end
      FAULT: begin
        fetch_fault = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        advance;
  logic [1:0]  pc_sel;
  logic [63:0] branch_offset;
  logic [63:0] reg_target;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        fetch_fault;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch #(.RESET_PC(64'h100)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .advance(advance), .pc_sel(pc_sel), .branch_offset(branch_offset), .reg_target(reg_target),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ack;
    logic        adv;
    logic [1:0]  sel;
    logic [63:0] off;
    logic [63:0] tgt;
    logic [31:0] data;
    logic        req;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ack, logic adv, logic [1:0] sel, logic [63:0] off,
                              logic [63:0] tgt, logic [31:0] data, logic req, logic valid,
                              logic [63:0] epc, logic [31:0] instr, logic fault);
    vec_t v;
    v.ack = ack; v.adv = adv; v.sel = sel; v.off = off; v.tgt = tgt; v.data = data;
    v.req = req; v.valid = valid; v.pc = epc; v.instr = instr; v.fault = fault;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_C3C3 ^ {a[47:32], 16'h0};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: word currently held (or not), sticky fault, current pc.
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_fault;

  task automatic model_reset();
    m_pc = 64'h100; m_instr = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_edge();
    logic [63:0] np;
    if (m_fault) return;
    if (!m_valid) begin
      if (imem_ack) begin
        m_instr = mem_word(m_pc);
        m_valid = 1'b1;
      end
    end else if (advance) begin
      if (pc_sel == 2'd1)      np = m_pc + branch_offset * 64'd4;
      else if (pc_sel == 2'd2) np = reg_target;
      else                     np = m_pc + 64'd4;
      m_pc    = np;
      m_valid = 1'b0;
      m_fault = (np % 64'd4) != 0;
    end
  endtask

  task automatic model_compare(string tag);
    check({tag, ".req"},   {63'h0, imem_req},    {63'h0, !m_valid && !m_fault});
    check({tag, ".valid"}, {63'h0, instr_valid}, {63'h0, m_valid});
    check({tag, ".fault"}, {63'h0, fetch_fault}, {63'h0, m_fault});
    check({tag, ".pc"},    pc,                   m_pc);
    check({tag, ".addr"},  imem_addr,            m_pc);
    check({tag, ".pc4"},   pc_plus4,             m_pc + 64'd4);
    if (m_valid) check({tag, ".instr"}, {32'h0, instruction}, {32'h0, m_instr});
  endtask

  initial begin
    logic [63:0] junk_off;
    logic [63:0] junk_tgt;
    junk_off = 64'h3;
    junk_tgt = 64'h998;

    // Reset, including an async reset landing mid-handshake with ack high
    reset = 1'b1; imem_ack = 1'b0; imem_data = 32'h0; advance = 1'b0;
    pc_sel = 2'b00; branch_offset = 64'h0; reg_target = 64'h0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("rst0.pc", pc, 64'h100);
    check("rst0.req", {63'h0, imem_req}, 64'h1);
    imem_ack = 1'b1; imem_data = 32'hA000_0100;
    @(posedge clock); #1;
    check("pre.valid", {63'h0, instr_valid}, 64'h1);
    #1 reset = 1'b1;
    #1;
    check("async.valid", {63'h0, instr_valid}, 64'h0);
    check("async.instr", {32'h0, instruction}, 64'h0);
    @(posedge clock); #1 reset = 1'b0;
    #1;
    check("rst.pc", pc, 64'h100);
    check("rst.req", {63'h0, imem_req}, 64'h1);
    check("rst.valid", {63'h0, instr_valid}, 64'h0);
    check("rst.instr", {32'h0, instruction}, 64'h0);
    check("rst.fault", {63'h0, fetch_fault}, 64'h0);
    imem_ack = 1'b0;

    // Directed table: sequential, wait states, stall, branches, wrap, fault
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_0100, 0, 1, 64'h100, 32'hA000_0100, 0));
    vecs.push_back(mk(0, 1, 2'b00, junk_off, junk_tgt, 32'h0,         1, 0, 64'h104, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_0104, 0, 1, 64'h104, 32'hA000_0104, 0));
    vecs.push_back(mk(0, 1, 2'b00, junk_off, junk_tgt, 32'h0,         1, 0, 64'h108, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_0108, 0, 1, 64'h108, 32'hA000_0108, 0));
    vecs.push_back(mk(0, 1, 2'b10, junk_off, 64'h200,  32'h0,         1, 0, 64'h200, 32'h0,         0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 2'b10, junk_off, 64'h800, 32'h0,        1, 0, 64'h200, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_0200, 0, 1, 64'h200, 32'hA000_0200, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 2'b10, junk_off, 64'h800, 32'hDEAD_BEEF, 0, 1, 64'h200, 32'hA000_0200, 0));
    vecs.push_back(mk(0, 1, 2'b01, -64'sd2,  junk_tgt, 32'h0,         1, 0, 64'h1F8, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_01F8, 0, 1, 64'h1F8, 32'hA000_01F8, 0));
    vecs.push_back(mk(0, 1, 2'b10, junk_off, 64'h200,  32'h0,         1, 0, 64'h200, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_0200, 0, 1, 64'h200, 32'hA000_0200, 0));
    vecs.push_back(mk(0, 1, 2'b01, 64'd5,    junk_tgt, 32'h0,         1, 0, 64'h214, 32'h0,         0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_0214, 0, 1, 64'h214, 32'hA000_0214, 0));
    vecs.push_back(mk(0, 1, 2'b10, junk_off, 64'h4000, 32'h0,         1, 0, 64'h4000, 32'h0,        0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_4000, 0, 1, 64'h4000, 32'hA000_4000, 0));
    vecs.push_back(mk(0, 1, 2'b10, junk_off, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'h9FFF_FFFC, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h9FFF_FFFC, 0));
    vecs.push_back(mk(0, 1, 2'b00, junk_off, junk_tgt, 32'h0,         1, 0, 64'h0,   32'h0,         0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_0000, 0, 1, 64'h0,   32'hA000_0000, 0));
    vecs.push_back(mk(0, 1, 2'b11, junk_off, junk_tgt, 32'h0,         1, 0, 64'h4,   32'h0,         0));
    vecs.push_back(mk(1, 0, 2'b00, junk_off, junk_tgt, 32'hA000_0004, 0, 1, 64'h4,   32'hA000_0004, 0));
    vecs.push_back(mk(0, 1, 2'b10, junk_off, 64'h4002, 32'h0,         0, 0, 64'h4002, 32'h0,        1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 1, 2'b10, junk_off, 64'h4000, 32'h1234_5678, 0, 0, 64'h4002, 32'h0,      1));

    foreach (vecs[i]) begin
      imem_ack = vecs[i].ack; advance = vecs[i].adv; pc_sel = vecs[i].sel;
      branch_offset = vecs[i].off; reg_target = vecs[i].tgt; imem_data = vecs[i].data;
      @(posedge clock); #1;
      check($sformatf("vec%0d.req", i),   {63'h0, imem_req},    {63'h0, vecs[i].req});
      check($sformatf("vec%0d.valid", i), {63'h0, instr_valid}, {63'h0, vecs[i].valid});
      check($sformatf("vec%0d.fault", i), {63'h0, fetch_fault}, {63'h0, vecs[i].fault});
      check($sformatf("vec%0d.pc", i),    pc,                   vecs[i].pc);
      check($sformatf("vec%0d.addr", i),  imem_addr,            vecs[i].pc);
      check($sformatf("vec%0d.pc4", i),   pc_plus4,             vecs[i].pc + 64'd4);
      if (vecs[i].valid)
        check($sformatf("vec%0d.instr", i), {32'h0, instruction}, {32'h0, vecs[i].instr});
    end

    // Only reset leaves FAULT
    #1 reset = 1'b1;
    #1;
    check("flt_rst.fault", {63'h0, fetch_fault}, 64'h0);
    check("flt_rst.pc", pc, 64'h100);
    check("flt_rst.req", {63'h0, imem_req}, 64'h1);
    @(posedge clock); #1 reset = 1'b0;
    model_reset();

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      int k;
      int r;
      imem_ack = ($urandom_range(0, 2) != 0);
      advance  = $urandom_range(0, 1);
      pc_sel   = 2'($urandom_range(0, 3));
      k = int'($urandom_range(0, 31)) - 16;
      branch_offset = 64'(k);
      r = int'($urandom_range(0, 19));
      if (r == 0)      reg_target = ({$urandom, $urandom} & ~64'h3) | 64'($urandom_range(1, 3));
      else if (r == 1) reg_target = 64'hFFFF_FFFF_FFFF_FFF8;
      else             reg_target = {32'h0, $urandom} & ~64'h3;
      imem_data = mem_word(m_pc);
      @(posedge clock);
      model_edge();
      #1;
      model_compare($sformatf("rnd%0d", c));
      if (m_fault && $urandom_range(0, 3) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        check($sformatf("rnd%0d.rst_pc", c), pc, 64'h100);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
